// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller.
// The INTR_EDGE_EN build macro is consumed by intr_ctrl, not here.
package intr_pkg;

    localparam int NLINES = 8;
    localparam int IDW    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: bit 0 wins.
// valid is high when any input bit is set.
module intr_prio_enc
    import intr_pkg::*;
(
    input  logic [NLINES-1:0] req,
    output logic [IDW-1:0]    idx,
    output logic              valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan from the top so the lowest set bit is the last to write idx.
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (req[i]) idx = IDW'(i);
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Single-level interrupt controller: mask, pending capture, IDLE/REQ/SERVICE handshake.
// Define INTR_EDGE_EN for edge-triggered pending bits; the default build is level mode.
module intr_ctrl #(
    parameter int NLINES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NLINES-1:0]      intr,
    input  logic                   mask_we,
    input  logic [NLINES-1:0]      mask_wdata,
    output logic [NLINES-1:0]      mask,
    output logic [NLINES-1:0]      pending,
    output logic                   irq_req,
    output logic [intr_pkg::IDW-1:0] irq_id,
    input  logic                   irq_ack,
    input  logic                   eret,
    output logic                   in_service,
    output intr_pkg::state_t       dbg_state
);

    import intr_pkg::*;

    // Handshake: irq_req/irq_id are held until irq_ack is seen in REQ;
    // eret is only honoured in SERVICE. Stray strobes in other states are ignored.
    state_t            state;
    logic [NLINES-1:0] eligible;
    logic [NLINES-1:0] pend_next;
    logic [IDW-1:0]    sel_id;
    logic              sel_valid;

    assign eligible  = pending & mask;
    assign dbg_state = state;

    intr_prio_enc u_prio (
        .req   (eligible),
        .idx   (sel_id),
        .valid (sel_valid)
    );

`ifdef INTR_EDGE_EN
    logic [NLINES-1:0] intr_s;
    logic [NLINES-1:0] rise;
    logic [NLINES-1:0] clr;

    assign rise = intr & ~intr_s;
    assign clr  = (state == ST_REQ && irq_ack) ? (NLINES'(1) << irq_id) : '0;
    // A fresh rising edge beats the acknowledge clear.
    assign pend_next = (pending & ~clr) | rise;

    always_ff @(posedge clk) begin
        if (rst) intr_s <= '0;
        else     intr_s <= intr;
    end
`else
    assign pend_next = intr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mask       <= '0;
            pending    <= '0;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            pending <= pend_next;
            if (mask_we) mask <= mask_wdata;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state   <= ST_REQ;
                        irq_req <= 1'b1;
                        irq_id  <= sel_id;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state      <= ST_SERVICE;
                        irq_req    <= 1'b0;
                        irq_id     <= '0;
                        in_service <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (eret) begin
                        state      <= ST_IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    irq_req    <= 1'b0;
                    irq_id     <= '0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NLINES, default 8, number of external interrupt lines; only 8 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 intr  input  8  raw interrupt lines, synchronous to clk; bit 0 has the highest priority.
REQ-005 mask_we  input  1  mask write strobe.
REQ-006 mask_wdata  input  8  new mask value; 1 = line enabled.
REQ-007 mask  output  8  current mask register.
REQ-008 pending  output  8  current pending register.
REQ-009 irq_req  output  1  interrupt request to the pipeline.
REQ-010 irq_id  output  3  index of the requested line, valid while irq_req=1.
REQ-011 irq_ack  input  1  pipeline accepts the request (exception taken).
REQ-012 eret  input  1  pipeline retired ERET; ends service.
REQ-013 in_service  output  1  high while a handler is running.

Function
REQ-014 The FSM states SHALL be IDLE, REQ and SERVICE, encoded with a 2-bit type.
REQ-015 In level mode, pending SHALL be the previous cycle's sample of intr: intr high before edge k gives pending[i]=1 after edge k.
REQ-016 In IDLE, if (pending & mask) != 0, the block SHALL enter REQ on the next edge, with irq_id latched as the lowest-index set bit of (pending & mask).
REQ-017 Therefore irq_req SHALL rise one edge after pending rises, i.e. two edges after intr rises.
REQ-018 In REQ, irq_req=1 and irq_id SHALL stay frozen until irq_ack, even if the line drops or the mask changes.
REQ-019 irq_ack in REQ SHALL move the block to SERVICE on the next edge: irq_req=0, in_service=1.
REQ-020 In SERVICE, no new request SHALL be raised (no nesting); eret SHALL return the block to IDLE on the next edge.
REQ-021 eret outside SERVICE and irq_ack outside REQ SHALL be ignored.
REQ-022 mask_we SHALL update mask on the next edge in any state; the new mask is used from that edge onward.
REQ-023 If a mask write and an IDLE-to-REQ evaluation happen in the same cycle, the old mask SHALL be used.
REQ-024 irq_id SHALL read 0 when irq_req=0.

Reset
REQ-025 rst SHALL take effect on a rising edge regardless of state: FSM=IDLE, mask=8'h00, pending=8'h00, irq_req=0, irq_id=0, in_service=0, sample registers cleared.
REQ-026 Reset during REQ or SERVICE SHALL abandon the request or service with no acknowledgement required.
REQ-027 While rst is high, irq_ack, eret and mask_we SHALL be ignored.

Configuration
REQ-028 Macro INTR_EDGE_EN defined: each pending bit SHALL be set on a 0-to-1 transition of the sampled intr bit, and cleared on the edge where irq_ack accepts that irq_id. A new rising edge in the same cycle as the clear SHALL win (bit stays set).
REQ-029 Macro INTR_EDGE_EN undefined: level mode as in REQ-015; irq_ack SHALL NOT alter pending.

Structure
REQ-030 Package intr_pkg SHALL hold the FSM state typedef and the constants NLINES=8 and IDW=3.
REQ-031 Priority selection SHALL be a combinational sub-module intr_prio_enc (8-bit in; 3-bit index plus valid out).

Verification
REQ-032 Reset, then mask_we with 8'hFF; drive intr=8'h20 -> pending=8'h20 after 1 edge, irq_req=1 with irq_id=5 after 2 edges.
REQ-033 mask=8'hFF, intr=8'h0A at once -> irq_id=1; pulse irq_ack -> in_service=1 and irq_req=0; pulse eret -> IDLE, then a new request with irq_id=1 (level mode) or irq_id=3 (edge mode).
REQ-034 mask=8'h00, intr=8'hFF for 10 cycles -> irq_req stays 0; then mask_we with 8'h80 -> irq_req=1 with irq_id=7 one edge after the mask write.
REQ-035 In REQ with irq_id=2, drop intr and write mask=8'h00 -> irq_req stays 1 and irq_id stays 2 until irq_ack.
REQ-036 rst asserted in SERVICE for 1 cycle -> all outputs and registers at reset values on the next edge; eret afterwards has no effect.
REQ-037 Edge mode: hold intr[4]=1 through irq_ack and eret -> no second request; drop it and raise it again -> a new request with irq_id=4.
